// File: rtl/bcd_uart_pkg.sv
// Shared types and constants for the BCD-to-ASCII UART line transmitter.
// Also holds the digit/character mapping helpers used by the sequencer.
package bcd_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_ERR  = 8'h3F;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;
  localparam int         FRAME_BITS = 10;
  localparam int         LINE_CHARS = 4;

  // Non-BCD codes (10..15) print as '?' so a converter fault is visible on the terminal.
  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (ASCII_ZERO + {4'h0, d}) : ASCII_ERR;
  endfunction

  function automatic logic [7:0] line_char(input logic [1:0] idx,
                                           input logic [3:0] t,
                                           input logic [3:0] o);
    logic [7:0] c;
    case (idx)
      2'd0:    c = digit_ascii(t);
      2'd1:    c = digit_ascii(o);
      2'd2:    c = ASCII_CR;
      default: c = ASCII_LF;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 serializer: tx goes low on the accept edge; 10*CLKS_PER_BIT cycles per frame.
// ready is high in IDLE and on the last stop-bit cycle, so frames chain with no gap.
module uart_tx_byte
  import bcd_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int               CW      = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]    BAUD_TC = CW'(CLKS_PER_BIT - 1);

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          baud_tc;

  assign baud_tc = (baud_cnt == BAUD_TC);
  assign ready   = (state == IDLE) || ((state == STOP) && baud_tc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= 8'h00;
      tx       <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (valid) begin
            shift <= data;
            tx    <= 1'b0;
            state <= START;
          end
        end
        START: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= shift[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        DATA: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
        default: begin
          if (baud_tc) begin
            baud_cnt <= '0;
            // Chain straight into the next start bit when the sequencer has another byte.
            if (valid) begin
              shift <= data;
              tx    <= 1'b0;
              state <= START;
            end else begin
              tx    <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/bcd_uart_tx.sv
// Sends "<tens><ones>\r\n" as 8N1; tx low on the accept edge, done 40 bit-times later.
// start while busy is dropped; BCD_UART_TX_BLANK_ZERO_EN skips a zero tens character.
module bcd_uart_tx
  import bcd_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] LAST_CHAR = 2'(LINE_CHARS - 1);

  logic [3:0] tens_q, ones_q;
  logic [1:0] char_idx;
  logic       accept, skip_tens;
  logic       byte_vld, byte_rdy;
  logic [7:0] byte_dat, first_dat;

  assign accept = start && !busy;

`ifdef BCD_UART_TX_BLANK_ZERO_EN
  assign skip_tens = (tens == 4'd0);
`else
  assign skip_tens = 1'b0;
`endif

  assign first_dat = skip_tens ? digit_ascii(ones) : digit_ascii(tens);

  // The first byte comes straight from the inputs so the start bit begins on the accept edge.
  always_comb begin
    byte_vld = 1'b0;
    byte_dat = first_dat;
    if (busy) begin
      byte_vld = (char_idx != LAST_CHAR);
      byte_dat = line_char(char_idx + 2'd1, tens_q, ones_q);
    end else begin
      byte_vld = start;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      tens_q   <= 4'd0;
      ones_q   <= 4'd0;
      char_idx <= 2'd0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        busy     <= 1'b1;
        tens_q   <= tens;
        ones_q   <= ones;
        char_idx <= skip_tens ? 2'd1 : 2'd0;
      end else if (busy && byte_rdy) begin
        if (char_idx == LAST_CHAR) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          char_idx <= 2'd0;
        end else begin
          char_idx <= char_idx + 2'd1;
        end
      end
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(byte_vld),
    .data (byte_dat),
    .ready(byte_rdy),
    .tx   (tx)
  );

endmodule

// File: tb/tb_bcd_uart_tx.sv
// Directed bench for bcd_uart_tx at CLKS_PER_BIT=4 (dut0) and CLKS_PER_BIT=1 (dut1).
module tb_bcd_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic [3:0] tens0 = 4'd0, ones0 = 4'd0, tens1 = 4'd0, ones1 = 4'd0;
  logic       tx0, busy0, done0, tx1, busy1, done1;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  bcd_uart_tx #(.CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .tens(tens0), .ones(ones0),
    .tx(tx0), .busy(busy0), .done(done0)
  );

  bcd_uart_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .tens(tens1), .ones(ones1),
    .tx(tx1), .busy(busy1), .done(done1)
  );

  function automatic logic [2:0] obs(input bit sel);
    return sel ? {tx1, busy1, done1} : {tx0, busy0, done0};
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start1 = v; else start0 = v;
  endtask

  task automatic set_digits(input bit sel, input logic [3:0] t, input logic [3:0] o);
    if (sel) begin tens1 = t; ones1 = o; end
    else begin tens0 = t; ones0 = o; end
  endtask

  task automatic check3(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: tx/busy/done observed %b expected %b", tag, got, exp);
    end
  endtask

  // Drive a request on a negedge; returns just after the accept edge E.
  task automatic launch(input bit sel, input logic [3:0] t, input logic [3:0] o);
    @(negedge clk);
    set_digits(sel, t, o);
    set_start(sel, 1'b1);
    @(posedge clk);
  endtask

  // Checks every cycle of the line from edge E, then the done cycle at E+10*nch*cpb.
  task automatic run_body(input bit sel, input int cpb, input int nch,
                          input logic [7:0] c0, input logic [7:0] c1,
                          input logic [7:0] c2, input logic [7:0] c3,
                          input bit hold, input bit chg, input bit poke,
                          input string tag);
    logic [7:0] ch [4];
    logic       eb;
    logic [2:0] bad;
    bit         ok;
    int         fb, cyc;
    ch[0] = c0; ch[1] = c1; ch[2] = c2; ch[3] = c3;
    for (int k = 0; k < nch * 10; k++) begin
      fb  = k % 10;
      eb  = (fb == 0) ? 1'b0 : (fb == 9) ? 1'b1 : ch[k / 10][fb - 1];
      ok  = 1'b1;
      bad = 3'b000;
      for (int c = 0; c < cpb; c++) begin
        cyc = k * cpb + c;
        @(negedge clk);
        if (cyc == 0 && !hold) set_start(sel, 1'b0);
        if (chg && cyc == 10) set_digits(sel, 4'd5, 4'd6);
        if (poke && cyc == 50) begin set_start(sel, 1'b1); set_digits(sel, 4'd9, 4'd9); end
        if (poke && cyc == 51) set_start(sel, 1'b0);
        if (obs(sel) !== {eb, 2'b10}) begin ok = 1'b0; bad = obs(sel); end
      end
      checks++;
      assert (ok === 1'b1) else begin
        errors++;
        $error("FAIL %s bit %0d: tx/busy/done observed %b expected %b10", tag, k, bad, eb);
      end
    end
    @(negedge clk);
    check3({tag, " done"}, obs(sel), 3'b101);
  endtask

  initial begin
    #400_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check3("reset dut0", obs(0), 3'b100);
    check3("reset dut1", obs(1), 3'b100);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check3("idle dut0", obs(0), 3'b100);

    // 42 with a one-cycle start pulse: 160 busy cycles then done.
    launch(0, 4'd4, 4'd2);
    run_body(0, 4, 4, 8'h34, 8'h32, 8'h0D, 8'h0A, 0, 0, 0, "l42");
    @(negedge clk);
    check3("l42 after", obs(0), 3'b100);

    // Zero tens digit.
    launch(0, 4'd0, 4'd7);
`ifdef BCD_UART_TX_BLANK_ZERO_EN
    run_body(0, 4, 3, 8'h37, 8'h0D, 8'h0A, 8'h00, 0, 0, 0, "l07");
`else
    run_body(0, 4, 4, 8'h30, 8'h37, 8'h0D, 8'h0A, 0, 0, 0, "l07");
`endif

    // Non-BCD tens, with a start pulse mid-line that must be dropped.
    launch(0, 4'hA, 4'd3);
    run_body(0, 4, 4, 8'h3F, 8'h33, 8'h0D, 8'h0A, 0, 0, 1, "lA3");
    @(negedge clk);
    check3("lA3 no queue 1", obs(0), 3'b100);
    @(negedge clk);
    check3("lA3 no queue 2", obs(0), 3'b100);

    launch(0, 4'd9, 4'hF);
    run_body(0, 4, 4, 8'h39, 8'h3F, 8'h0D, 8'h0A, 0, 0, 0, "l9F");

    // start held high: second line accepted the edge after done, one idle cycle between.
    launch(0, 4'd1, 4'd2);
    run_body(0, 4, 4, 8'h31, 8'h32, 8'h0D, 8'h0A, 1, 1, 0, "b2b1");
    @(posedge clk);
    run_body(0, 4, 4, 8'h35, 8'h36, 8'h0D, 8'h0A, 0, 0, 0, "b2b2");

    // Reset during data bit 3 of character 1 (line bit 14, cycles E+56..E+59).
    launch(0, 4'd4, 4'd2);
    for (int i = 0; i < 58; i++) begin
      @(negedge clk);
      if (i == 0) set_start(0, 1'b0);
    end
    check3("pre-reset", obs(0), 3'b010);
    rst_n = 1'b0;
    #1;
    check3("async reset", obs(0), 3'b100);
    @(negedge clk);
    rst_n = 1'b1;
    launch(0, 4'd7, 4'd8);
    run_body(0, 4, 4, 8'h37, 8'h38, 8'h0D, 8'h0A, 0, 0, 0, "post-rst");

    // One clock per bit: 40-cycle line.
    launch(1, 4'd1, 4'd0);
    run_body(1, 1, 4, 8'h31, 8'h30, 8'h0D, 8'h0A, 0, 0, 0, "cpb1");
    @(negedge clk);
    check3("cpb1 after", obs(1), 3'b100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_uart_tx.md
# bcd_uart_tx

Transmits a two-digit BCD value as an ASCII text line over an 8N1 UART serial output. Digits come from the binary-to-BCD converter (tens, ones). The block sits directly downstream of that converter and drives the board's UART TX pin. One accepted request sends one line: tens character, ones character, CR, LF. The block sequences four byte frames with a baud-rate counter and reports completion with busy/done.

## Interface
- CLKS_PER_BIT, default 104: clock cycles per serial bit (12 MHz / 115200); legal range 1..65535.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request to send a line; sampled on each rising edge.
- tens  in  4  BCD tens digit; latched when a request is accepted.
- ones  in  4  BCD ones digit; latched when a request is accepted.
- tx  out  1  serial line; idles high.
- busy  out  1  high while a line is in progress.
- done  out  1  one-cycle pulse when the final stop bit of the line completes.

## Operation
- Accept rule: a request is accepted when start=1 and busy=0 at a rising edge. tens and ones are latched at that edge. start while busy=1 is ignored (not queued).
- Character mapping: a digit 0..9 maps to 0x30+digit. A digit 10..15 maps to 0x3F ('?').
- Line content: tens char, ones char, 0x0D, 0x0A.
- Frame per character: start bit 0, then 8 data bits LSB first, then stop bit 1. That is 10 bits, each held exactly CLKS_PER_BIT cycles.
- FSM states:
  - IDLE: tx=1. On accept, go to START.
  - START: tx=0.
  - DATA: tx=shift[0]; a 3-bit bit index counts 0..7.
  - STOP: tx=1. At the end of STOP, go to START with the next character if one remains; otherwise go to IDLE with done pulsed.
- Counters:
  - Baud counter is $clog2(CLKS_PER_BIT+1) bits wide. It counts 0..CLKS_PER_BIT-1 and advances bit state at terminal count.
  - Character index is 2 bits.
- Reset values: tx=1, busy=0, done=0, state IDLE, all counters 0.
- Reset mid-line: the line is abandoned immediately and asynchronously. tx returns to 1 with no partial stop bit. The first start after reset release gives a clean line.

## Timing
- The accept edge is edge E.
- From edge E: busy=1 and tx=0. The start bit of character 0 covers cycles E+1..E+CLKS_PER_BIT.
- Bit k of the line (k=0..39) drives tx from edge E+k·CLKS_PER_BIT for CLKS_PER_BIT cycles.
- At edge E+40·CLKS_PER_BIT: busy=0, done=1, tx=1. done is low from the next edge.
- Back-to-back: start=1 during the done cycle is accepted at the following edge. The inter-line idle gap is exactly one cycle.
- There is no gap between the characters of one line: the STOP of character n is followed directly by the START of character n+1.

## Configuration
- Macro: BCD_UART_TX_BLANK_ZERO_EN.
- Defined: if the latched tens digit equals 0, the tens character is skipped. The line is then ones, CR, LF (30 bit times), and done fires at E+30·CLKS_PER_BIT. tens 1..15 behave as without the macro.
- Undefined: all four characters are always sent; tens=0 transmits 0x30.

## Structure
- Package bcd_uart_pkg:
  - state enum (IDLE, START, DATA, STOP);
  - constants ASCII_ZERO=8'h30, ASCII_ERR=8'h3F, ASCII_CR=8'h0D, ASCII_LF=8'h0A, FRAME_BITS=10, LINE_CHARS=4.
- Sub-module uart_tx_byte: a single-byte 8N1 serializer.
  - Ports: clk, rst_n, valid, data[7:0], ready, tx.
  - Parameter: CLKS_PER_BIT.
- bcd_uart_tx holds the character sequencer and the digit-to-ASCII mapping, and instantiates uart_tx_byte. The parent sequences characters and holds busy through every inter-character boundary.

## Test plan
All cases use CLKS_PER_BIT=4 unless noted.
- tens=4, ones=2, one-cycle start pulse -> tx decodes 0x34, 0x32, 0x0D, 0x0A. busy is high for 160 cycles, then done pulses once.
- tens=0, ones=7 -> with the macro: 0x37, 0x0D, 0x0A, done at E+120. Without the macro: 0x30, 0x37, 0x0D, 0x0A, done at E+160.
- tens=0xA, ones=3 -> 0x3F, 0x33, 0x0D, 0x0A. tens=9, ones=0xF -> 0x39, 0x3F, 0x0D, 0x0A.
- Hold start=1 continuously. Change tens/ones from 1,2 to 5,6 at E+10 -> the first line sends 0x31, 0x32. The second line is accepted the edge after done, sends 0x35, 0x36, and has a one-cycle idle gap between the lines.
- rst_n pulsed low during data bit 3 of character 1 -> tx=1, busy=0 and done=0 within the same cycle. A start after release yields a complete, correct line.
- CLKS_PER_BIT=1, tens=1, ones=0 -> the line completes in 40 cycles. tx bits match 8N1 framing of 0x31, 0x30, 0x0D, 0x0A.
